phy_tx_ctrl: RTL and testbench

PHY_TX_CTRL -- requirements
Module: phy_tx_ctrl

---
 rtl/phy_ctrl_pkg.sv | 35 +++
 rtl/phy_rate_lut.sv | 28 ++
 rtl/phy_tx_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_phy_tx_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_ctrl_pkg.sv
// Shared definitions for the 802.11a transmit controller: FSM state
// encoding and the RATE-code to data-bits-per-symbol table.
package phy_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_WAIT_RDY = 3'd2,
      ST_STREAM   = 3'd3,
      ST_PAD      = 3'd4,
      ST_DRAIN    = 3'd5,
      ST_DONE     = 3'd6
   } state_e;

   // RATE field codes (4-bit, as carried in the SIGNAL field)
   localparam logic [3:0] RATE_6M  = 4'b1101;
   localparam logic [3:0] RATE_9M  = 4'b1111;
   localparam logic [3:0] RATE_12M = 4'b0101;
   localparam logic [3:0] RATE_18M = 4'b0111;
   localparam logic [3:0] RATE_24M = 4'b1001;
   localparam logic [3:0] RATE_36M = 4'b1011;
   localparam logic [3:0] RATE_48M = 4'b0001;
   localparam logic [3:0] RATE_54M = 4'b0011;

   // Data bits per OFDM symbol for each rate
   localparam logic [7:0] NDBPS_6M  = 8'd24;
   localparam logic [7:0] NDBPS_9M  = 8'd36;
   localparam logic [7:0] NDBPS_12M = 8'd48;
   localparam logic [7:0] NDBPS_18M = 8'd72;
   localparam logic [7:0] NDBPS_24M = 8'd96;
   localparam logic [7:0] NDBPS_36M = 8'd144;
   localparam logic [7:0] NDBPS_48M = 8'd192;
   localparam logic [7:0] NDBPS_54M = 8'd216;

endpackage

// File: rtl/phy_rate_lut.sv
// Combinational decode of the RATE code into N_DBPS plus a validity flag.
// Unknown codes return N_DBPS = 0 and rate_ok = 0.
module phy_rate_lut
   import phy_ctrl_pkg::*;
(
   input  logic [3:0] rate,
   output logic [7:0] n_dbps,
   output logic       rate_ok
);

   // Map each of the eight legal codes to its symbol size
   always_comb begin
      n_dbps  = 8'd0;
      rate_ok = 1'b0;
      case (rate)
         RATE_6M:  begin n_dbps = NDBPS_6M;  rate_ok = 1'b1; end
         RATE_9M:  begin n_dbps = NDBPS_9M;  rate_ok = 1'b1; end
         RATE_12M: begin n_dbps = NDBPS_12M; rate_ok = 1'b1; end
         RATE_18M: begin n_dbps = NDBPS_18M; rate_ok = 1'b1; end
         RATE_24M: begin n_dbps = NDBPS_24M; rate_ok = 1'b1; end
         RATE_36M: begin n_dbps = NDBPS_36M; rate_ok = 1'b1; end
         RATE_48M: begin n_dbps = NDBPS_48M; rate_ok = 1'b1; end
         RATE_54M: begin n_dbps = NDBPS_54M; rate_ok = 1'b1; end
         default:  begin n_dbps = 8'd0;      rate_ok = 1'b0; end
      endcase
   end

endmodule

// File: rtl/phy_tx_ctrl.sv
// Frame-level transmit controller in front of an 802.11a PHY.
// Requests a frame, streams host payload bits with one cycle of latency,
// zero-pads to a whole number of OFDM symbols, then waits for the PHY
// output to go quiet before reporting completion. Every output is a flop;
// the combinational block computes next-cycle output values.
module phy_tx_ctrl
   import phy_ctrl_pkg::*;
#(
   parameter int DRAIN_IDLE = 200,
   parameter int LEN_W      = 12
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       rate_in,
   input  logic [LEN_W-1:0] len_bits,
   input  logic             abort,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic [3:0]       phy_rate,
   output logic             phy_tx_request,
   output logic             phy_in,
   output logic             phy_run,
   input  logic             phy_ready,
   input  logic             phy_valid,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [15:0]      out_cnt
);

   // Idle counter only has to hold 0 .. DRAIN_IDLE-1
   localparam int IDLE_W = (DRAIN_IDLE < 2) ? 1 : $clog2(DRAIN_IDLE);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_IDLE - 1);

   // Registered state and counters
   state_e             state_r;
   logic [LEN_W-1:0]   len_r;
   logic [LEN_W-1:0]   pay_cnt_r;
   logic [7:0]         sym_cnt_r;
   logic [IDLE_W-1:0]  idle_cnt_r;

   // Registered outputs
   logic               bit_ready_r;
   logic [3:0]         phy_rate_r;
   logic               phy_tx_request_r;
   logic               phy_in_r;
   logic               phy_run_r;
   logic               busy_r;
   logic               done_r;
   logic               err_r;
   logic [15:0]        out_cnt_r;

   // Next-cycle values
   state_e             state_s;
   logic [LEN_W-1:0]   len_s;
   logic [LEN_W-1:0]   pay_cnt_s;
   logic [7:0]         sym_cnt_s;
   logic [IDLE_W-1:0]  idle_cnt_s;
   logic               bit_ready_s;
   logic [3:0]         phy_rate_s;
   logic               phy_tx_request_s;
   logic               phy_in_s;
   logic               phy_run_s;
   logic               busy_s;
   logic               done_s;
   logic               err_s;
   logic [15:0]        out_cnt_s;

   // Helper terms
   logic [3:0]         lut_rate_s;
   logic [7:0]         n_dbps_s;
   logic               rate_ok_s;
   logic [7:0]         sym_inc_s;
   logic [LEN_W-1:0]   pay_inc_s;
   logic               in_frame_s;

   // While idle the LUT validates the requested rate; during a frame it
   // supplies the symbol size of the latched rate.
   assign lut_rate_s = (state_r == ST_IDLE) ? rate_in : phy_rate_r;

   phy_rate_lut u_rate_lut (
      .rate    (lut_rate_s),
      .n_dbps  (n_dbps_s),
      .rate_ok (rate_ok_s)
   );

   // Symbol counter advance with wrap at N_DBPS-1, and payload advance
   always_comb begin
      if (sym_cnt_r == (n_dbps_s - 8'd1)) begin
         sym_inc_s = 8'd0;
      end else begin
         sym_inc_s = sym_cnt_r + 8'd1;
      end
      pay_inc_s  = pay_cnt_r + LEN_W'(1);
      in_frame_s = (state_r != ST_IDLE) && (state_r != ST_DONE);
   end

   // Next-state and next-output computation
   always_comb begin
      state_s          = state_r;
      len_s            = len_r;
      pay_cnt_s        = pay_cnt_r;
      sym_cnt_s        = sym_cnt_r;
      idle_cnt_s       = idle_cnt_r;
      phy_rate_s       = phy_rate_r;
      bit_ready_s      = 1'b0;
      phy_tx_request_s = 1'b0;
      phy_in_s         = 1'b0;
      phy_run_s        = 1'b0;
      done_s           = 1'b0;
      err_s            = 1'b0;

      // PHY output activity is counted from REQ through DRAIN, saturating
      if (in_frame_s && phy_valid && (out_cnt_r != 16'hFFFF)) begin
         out_cnt_s = out_cnt_r + 16'd1;
      end else begin
         out_cnt_s = out_cnt_r;
      end

      if (abort && (state_r != ST_IDLE)) begin
         // Cancel the frame: back to idle with an error pulse, nothing sent
         state_s    = ST_IDLE;
         idle_cnt_s = {IDLE_W{1'b0}};
         err_s      = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (abort) begin
                  // Abort beats a simultaneous start; no error in idle
                  state_s = ST_IDLE;
               end else if (start) begin
                  if (rate_ok_s && (len_bits != {LEN_W{1'b0}})) begin
                     state_s          = ST_REQ;
                     phy_rate_s       = rate_in;
                     len_s            = len_bits;
                     pay_cnt_s        = {LEN_W{1'b0}};
                     sym_cnt_s        = 8'd0;
                     idle_cnt_s       = {IDLE_W{1'b0}};
                     out_cnt_s        = 16'd0;
                     phy_tx_request_s = 1'b1;
                  end else begin
                     err_s = 1'b1;
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end

            ST_REQ: begin
               state_s = ST_WAIT_RDY;
            end

            ST_WAIT_RDY: begin
               if (phy_ready) begin
                  state_s     = ST_STREAM;
                  bit_ready_s = 1'b1;
               end else begin
                  state_s = ST_WAIT_RDY;
               end
            end

            ST_STREAM: begin
               if (bit_valid) begin
                  phy_in_s  = bit_in;
                  phy_run_s = 1'b1;
                  pay_cnt_s = pay_inc_s;
                  sym_cnt_s = sym_inc_s;
                  if (pay_inc_s == len_r) begin
                     // Last payload bit: pad only if the symbol is partial
                     bit_ready_s = 1'b0;
                     if (sym_inc_s == 8'd0) begin
                        state_s = ST_DRAIN;
                     end else begin
                        state_s = ST_PAD;
                     end
                  end else begin
                     bit_ready_s = 1'b1;
                  end
               end else begin
                  bit_ready_s = 1'b1;
               end
            end

            ST_PAD: begin
               phy_in_s  = 1'b0;
               phy_run_s = 1'b1;
               sym_cnt_s = sym_inc_s;
               if (sym_inc_s == 8'd0) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_PAD;
               end
            end

            ST_DRAIN: begin
               if (phy_valid) begin
                  idle_cnt_s = {IDLE_W{1'b0}};
               end else if (idle_cnt_r == IDLE_LAST) begin
                  idle_cnt_s = {IDLE_W{1'b0}};
                  state_s    = ST_DONE;
                  done_s     = 1'b1;
               end else begin
                  idle_cnt_s = idle_cnt_r + IDLE_W'(1);
               end
            end

            ST_DONE: begin
               state_s = ST_IDLE;
            end

            default: begin
               state_s    = ST_IDLE;
               idle_cnt_s = {IDLE_W{1'b0}};
            end
         endcase
      end

      busy_s = (state_s != ST_IDLE);
   end

   // State, counter and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r          <= ST_IDLE;
         len_r            <= {LEN_W{1'b0}};
         pay_cnt_r        <= {LEN_W{1'b0}};
         sym_cnt_r        <= 8'd0;
         idle_cnt_r       <= {IDLE_W{1'b0}};
         bit_ready_r      <= 1'b0;
         phy_rate_r       <= 4'b0000;
         phy_tx_request_r <= 1'b0;
         phy_in_r         <= 1'b0;
         phy_run_r        <= 1'b0;
         busy_r           <= 1'b0;
         done_r           <= 1'b0;
         err_r            <= 1'b0;
         out_cnt_r        <= 16'd0;
      end else begin
         state_r          <= state_s;
         len_r            <= len_s;
         pay_cnt_r        <= pay_cnt_s;
         sym_cnt_r        <= sym_cnt_s;
         idle_cnt_r       <= idle_cnt_s;
         bit_ready_r      <= bit_ready_s;
         phy_rate_r       <= phy_rate_s;
         phy_tx_request_r <= phy_tx_request_s;
         phy_in_r         <= phy_in_s;
         phy_run_r        <= phy_run_s;
         busy_r           <= busy_s;
         done_r           <= done_s;
         err_r            <= err_s;
         out_cnt_r        <= out_cnt_s;
      end
   end

   assign bit_ready      = bit_ready_r;
   assign phy_rate       = phy_rate_r;
   assign phy_tx_request = phy_tx_request_r;
   assign phy_in         = phy_in_r;
   assign phy_run        = phy_run_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign err            = err_r;
   assign out_cnt        = out_cnt_r;

endmodule

// File: tb/tb_phy_tx_ctrl.sv
// Self-checking bench for phy_tx_ctrl. Frames are driven cycle by cycle;
// expectations come from the frame rules: payload bits echoed one cycle
// later, zero padding up to a whole number of symbols, a drain that ends
// after DI consecutive quiet PHY cycles, and a count of phy_valid cycles.
module tb_phy_tx_ctrl;

   localparam int DI = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  rate_in;
   logic [11:0] len_bits;
   logic        abort;
   logic        bit_in;
   logic        bit_valid;
   logic        bit_ready;
   logic [3:0]  phy_rate;
   logic        phy_tx_request;
   logic        phy_in;
   logic        phy_run;
   logic        phy_ready;
   logic        phy_valid;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] out_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   phy_tx_ctrl #(.DRAIN_IDLE(DI), .LEN_W(12)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .rate_in        (rate_in),
      .len_bits       (len_bits),
      .abort          (abort),
      .bit_in         (bit_in),
      .bit_valid      (bit_valid),
      .bit_ready      (bit_ready),
      .phy_rate       (phy_rate),
      .phy_tx_request (phy_tx_request),
      .phy_in         (phy_in),
      .phy_run        (phy_run),
      .phy_ready      (phy_ready),
      .phy_valid      (phy_valid),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .out_cnt        (out_cnt)
   );

   always #5 clk = ~clk;

   // Reference symbol size: 4 data bits per symbol per Mbit/s of rate
   function automatic int ref_ndbps(input logic [3:0] r);
      int mbps;
      case (r)
         4'b1101: mbps = 6;
         4'b1111: mbps = 9;
         4'b0101: mbps = 12;
         4'b0111: mbps = 18;
         4'b1001: mbps = 24;
         4'b1011: mbps = 36;
         4'b0001: mbps = 48;
         4'b0011: mbps = 54;
         default: mbps = 0;
      endcase
      return mbps * 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bit_ready"}, bit_ready, 0);
      chk({tag, "_req"}, phy_tx_request, 0);
      chk({tag, "_phy_in"}, phy_in, 0);
      chk({tag, "_phy_run"}, phy_run, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_rate"}, phy_rate, 0);
      chk({tag, "_out_cnt"}, out_cnt, 0);
   endtask

   // Rejected or suppressed start request while idle
   task automatic try_bad(input logic [3:0] r, input int len, input logic ab, input logic exp_err);
      rate_in = r; len_bits = 12'(len); start = 1'b1; abort = ab;
      step();
      start = 1'b0; abort = 1'b0;
      chk("bad_err", err, exp_err);
      chk("bad_busy", busy, 0);
      chk("bad_req", phy_tx_request, 0);
      step();
      chk("bad_err_clear", err, 0);
      chk("bad_busy_after", busy, 0);
   endtask

   // One frame. vmode: 0 always valid, 1 toggling, 2 random.
   // abort_at > 0 aborts while the abort_at-th payload bit is offered.
   // rst_pad_at > 0 resets on that pad cycle.
   task automatic run_frame(input logic [3:0] r, input int len, input int vmode,
                            input int abort_at, input int rst_pad_at);
      int n, total, pad, acc, cyc, zc, oc, sent, w;
      logic bv, bi, pv;
      n     = ref_ndbps(r);
      total = ((len + n - 1) / n) * n;
      pad   = total - len;
      oc    = 0;
      sent  = 0;

      rate_in = r; len_bits = 12'(len); start = 1'b1;
      phy_valid = 1'b0; phy_ready = 1'b0; bit_valid = 1'b0;
      step();
      chk("req_pulse", phy_tx_request, 1);
      chk("busy_on", busy, 1);
      chk("rate_latched", phy_rate, r);
      chk("out_cnt_clr", out_cnt, 0);

      // Another start with a different rate while busy must be ignored
      rate_in = ~r;
      pv = 1'($urandom_range(1, 0)); phy_valid = pv; oc += int'(pv);
      step();
      chk("req_one_cycle", phy_tx_request, 0);

      w = $urandom_range(3, 0);
      for (int i = 0; i < w; i++) begin
         pv = 1'($urandom_range(1, 0)); phy_valid = pv; oc += int'(pv);
         step();
         chk("wait_no_ready", bit_ready, 0);
         chk("wait_no_run", phy_run, 0);
      end
      phy_ready = 1'b1;
      pv = 1'($urandom_range(1, 0)); phy_valid = pv; oc += int'(pv);
      step();
      phy_ready = 1'b0; start = 1'b0;
      chk("stream_ready_on", bit_ready, 1);
      chk("rate_hold", phy_rate, r);

      acc = 0; cyc = 0;
      while (acc < len && cyc < 20000) begin
         if (abort_at != 0 && acc == abort_at - 1) begin
            abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; phy_valid = 1'b0;
            step();
            abort = 1'b0; bit_valid = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_ready", bit_ready, 0);
            chk("abort_run", phy_run, 0);
            chk("abort_err", err, 1);
            chk("abort_done", done, 0);
            step();
            chk("abort_err_clear", err, 0);
            for (int i = 0; i < 2 * DI; i++) begin
               step();
               chk("abort_no_done", done, 0);
               chk("abort_no_run", phy_run, 0);
            end
            return;
         end
         case (vmode)
            0:       bv = 1'b1;
            1:       bv = (cyc % 2 == 0);
            default: bv = 1'($urandom_range(1, 0));
         endcase
         bi = 1'($urandom_range(1, 0));
         bit_valid = bv; bit_in = bi;
         pv = 1'($urandom_range(1, 0)); phy_valid = pv; oc += int'(pv);
         step();
         cyc++;
         acc += int'(bv);
         sent += int'(phy_run);
         chk("stream_run", phy_run, bv);
         if (bv) chk("stream_bit", phy_in, bi);
         chk("stream_ready", bit_ready, acc < len);
      end
      chk("stream_timeout", acc, len);
      if (vmode == 1) chk("toggle_span", cyc, 2 * len - 1);

      for (int i = 0; i < pad; i++) begin
         bit_valid = 1'($urandom_range(1, 0)); bit_in = 1'b1;
         if (rst_pad_at != 0 && i == rst_pad_at) begin
            rst = 1'b0; phy_valid = 1'b0;
            step();
            rst = 1'b1; bit_valid = 1'b0;
            chk_reset_vals("rst_pad");
            step();
            chk_reset_vals("rst_pad_after");
            return;
         end
         pv = 1'($urandom_range(1, 0)); phy_valid = pv; oc += int'(pv);
         step();
         sent += int'(phy_run);
         chk("pad_run", phy_run, 1);
         chk("pad_zero", phy_in, 0);
         chk("pad_ready", bit_ready, 0);
      end
      chk("total_bits", sent, total);

      bit_valid = 1'b0;
      zc = 0; cyc = 0;
      while (cyc < 1000) begin
         pv = (cyc < 8) ? 1'($urandom_range(1, 0)) : 1'b0;
         phy_valid = pv; oc += int'(pv);
         if (pv) zc = 0; else zc++;
         step();
         cyc++;
         chk("drain_run", phy_run, 0);
         if (zc == DI) break;
         chk("drain_no_done", done, 0);
      end
      chk("done_pulse", done, 1);
      chk("busy_in_done", busy, 1);
      chk("rate_in_done", phy_rate, r);

      phy_valid = 1'b1;
      step();
      phy_valid = 1'b1;
      chk("done_one_cycle", done, 0);
      chk("busy_off", busy, 0);
      chk("out_cnt", out_cnt, oc);
      step();
      phy_valid = 1'b0;
      chk("out_cnt_hold", out_cnt, oc);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; rate_in = 4'b0000; len_bits = 12'd0; abort = 1'b0;
      bit_in = 1'b0; bit_valid = 1'b0; phy_ready = 1'b0; phy_valid = 1'b0;
      step();
      step();
      chk_reset_vals("reset");
      rst = 1'b1;
      step();
      chk_reset_vals("idle");

      // Whole symbols, no padding
      run_frame(4'b1001, 96, 0, 0, 0);
      // 50 payload bits plus 22 pad bits
      run_frame(4'b1101, 50, 0, 0, 0);
      // Toggling valid spreads 48 bits over twice as many cycles
      run_frame(4'b0101, 48, 1, 0, 0);

      // Rejected requests
      try_bad(4'b0000, 10, 1'b0, 1'b1);
      try_bad(4'b1001, 0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         logic [3:0] rr;
         rr = 4'($urandom_range(15, 0));
         if (ref_ndbps(rr) == 0) try_bad(rr, $urandom_range(100, 1), 1'b0, 1'b1);
         else                   try_bad(rr, 0, 1'b0, 1'b1);
      end
      // Abort together with start in idle: nothing happens
      try_bad(4'b0000, 10, 1'b1, 1'b0);
      try_bad(4'b1001, 20, 1'b1, 1'b0);

      // Abort on the 10th payload bit
      run_frame(4'b1011, 100, 0, 10, 0);
      // Reset during padding, then a normal frame
      run_frame(4'b1101, 50, 0, 0, 5);
      run_frame(4'b0111, 30, 2, 0, 0);

      // Boundaries and random frames
      run_frame(4'b0011, 216, 2, 0, 0);
      run_frame(4'b1111, 1, 2, 0, 0);
      for (int i = 0; i < 6; i++) begin
         logic [3:0] rr;
         do rr = 4'($urandom_range(15, 0)); while (ref_ndbps(rr) == 0);
         run_frame(rr, $urandom_range(300, 1), 2, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
